// File: rtl/memcpy_pkg.sv
// Shared types and constants for the memcpy engine and its pointer generators.
package memcpy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } state_e;

  localparam int unsigned WORD_BYTES      = 4;
  localparam logic [31:0] DEFAULT_MEMSIZE = 32'h400;

endpackage

// File: rtl/memcpy_addr_gen.sv
// Word pointer: loads a start address (first or last word of the block) when a copy
// is accepted, then steps one word in the direction chosen at load time.
module memcpy_addr_gen
  import memcpy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        backward_i,
  input  logic [31:0] base_i,
  input  logic [15:0] len_words_i,
  output logic [31:0] ptr_o
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  logic [31:0] ptr_q, ptr_d;
  logic        back_q, back_d;
  logic [31:0] last_off;

  assign last_off = {14'b0, len_words_i, 2'b00} - STEP;
  assign ptr_o    = ptr_q;

  always_comb begin
    ptr_d  = ptr_q;
    back_d = back_q;
    if (load_i) begin
      back_d = backward_i;
      ptr_d  = backward_i ? base_i + last_off : base_i;
    end else if (step_i) begin
      ptr_d = back_q ? ptr_q - STEP : ptr_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      back_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      back_q <= back_d;
    end
  end

endmodule

// File: rtl/memcpy_engine.sv
// Word-granular memmove engine: alternates single-cycle reads and writes, copying
// backwards when the destination overlaps the tail of the source.
module memcpy_engine
  import memcpy_pkg::*;
#(
  parameter logic [31:0] MEMSIZE      = DEFAULT_MEMSIZE,
  parameter bit          DUMP_ON_DONE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        createdump
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] data_q, data_d;
  logic [32:0] span, src_end, dst_end;
  logic        misaligned, out_of_range, backward, accept, step;
  logic [31:0] src_ptr, dst_ptr;

  // Bounds are checked in 33 bits so an address near 2^32 cannot wrap into range.
  assign span         = {15'b0, len_words, 2'b00};
  assign src_end      = {1'b0, src_addr} + span;
  assign dst_end      = {1'b0, dst_addr} + span;
  assign misaligned   = (|src_addr[1:0]) || (|dst_addr[1:0]);
  assign out_of_range = (src_end > {1'b0, MEMSIZE}) || (dst_end > {1'b0, MEMSIZE});
  assign backward     = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
  assign accept       = (state_q == IDLE) && start;
  assign step         = (state_q == WRITE);

  memcpy_addr_gen u_src_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .step_i      (step),
    .backward_i  (backward),
    .base_i      (src_addr),
    .len_words_i (len_words),
    .ptr_o       (src_ptr)
  );

  memcpy_addr_gen u_dst_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .step_i      (step),
    .backward_i  (backward),
    .base_i      (dst_addr),
    .len_words_i (len_words),
    .ptr_o       (dst_ptr)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    data_d     = data_q;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    createdump = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = len_words;
          if (misaligned || out_of_range) state_d = ERR;
          else if (len_words == 16'd0)    state_d = DONE;
          else                            state_d = READ;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = src_ptr;
        data_d     = mem_rdata;
        state_d    = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = dst_ptr;
        mem_wdata  = data_q;
        count_d    = count_q - 16'd1;
        state_d    = (count_q == 16'd1) ? DONE : READ;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        createdump = DUMP_ON_DONE;
        state_d    = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state_q, so an async reset silences the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/memcpy_engine.md
MEMCPY_ENGINE -- requirements
Module: memcpy_engine

Interface
REQ-001 SHALL have parameter MEMSIZE, default 32'h400: byte size of the attached memory, used for bounds checks.
REQ-002 SHALL have parameter DUMP_ON_DONE, default 0: when 1, pulse createdump on successful completion.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 src_addr  input  32  byte address of the first source word.
REQ-008 dst_addr  input  32  byte address of the first destination word.
REQ-009 len_words  input  16  number of 32-bit words to copy.
REQ-010 busy  output  1  high in READ, WRITE and DONE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 error  output  1  one-cycle pulse, coincident with done, on a rejected request.
REQ-013 mem_enable  output  1  memory access strobe.
REQ-014 mem_wr  output  1  1 = write, 0 = read.
REQ-015 mem_addr  output  32  memory byte address.
REQ-016 mem_wdata  output  32  write data.
REQ-017 mem_rdata  input  32  read data, combinational and zero-delay from mem_addr.
REQ-018 createdump  output  1  memory dump request.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, DONE, ERR.
REQ-020 IDLE with start=1 SHALL latch all request inputs and take exactly one of these transitions on the same edge:
- ERR if src_addr[1:0] or dst_addr[1:0] is nonzero;
- ERR if 33-bit src_addr+4*len_words > MEMSIZE, or the same check on dst_addr fails;
- DONE if len_words == 0;
- READ otherwise.
REQ-021 READ SHALL drive mem_enable=1, mem_wr=0, mem_addr=current source pointer.
- The edge ending READ SHALL capture mem_rdata into a data register and move to WRITE.
REQ-022 WRITE SHALL drive mem_enable=1, mem_wr=1, mem_addr=current destination pointer, mem_wdata=data register.
- The edge ending WRITE SHALL step both pointers and decrement the remaining count.
- Next state SHALL be DONE if the count reaches 0, else READ.
REQ-023 A read and a write SHALL never be issued in the same cycle.
REQ-024 Direction SHALL be decided at start:
- Backward if dst_addr > src_addr and dst_addr < src_addr+4*len_words: pointers start at base+4*(len_words-1) and step -4.
- Forward otherwise: pointers start at base and step +4.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
- createdump SHALL be 1 in DONE only when DUMP_ON_DONE=1.
REQ-026 ERR SHALL last one cycle with done=1 and error=1, then go to IDLE, with no memory access.
REQ-027 Latency: for len_words=N>0 accepted at edge k, done SHALL be high in the cycle following edge k+2N.
REQ-028 start while not in IDLE SHALL be ignored; request inputs are don't-care after the accepting edge.
REQ-029 In IDLE, DONE and ERR, mem_enable, mem_wr, mem_addr and mem_wdata SHALL all be 0.
REQ-030 Address arithmetic SHALL be 32-bit; the bounds check SHALL be done in 33 bits so no wrap-around is accepted.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE and clear pointers, count and data register.
- It SHALL also force busy, done, error, createdump and all mem_* outputs to 0.
REQ-032 Reset mid-operation SHALL abort the copy immediately: mem_enable drops without waiting for clk, the in-flight word is not written, and no done is pulsed.

Structure
REQ-033 A shared package memcpy_pkg SHALL hold the state enumeration, WORD_BYTES=4, and the default MEMSIZE.
REQ-034 The pointer up/down step logic SHALL be one sub-module, memcpy_addr_gen, instantiated twice (source and destination).
REQ-035 The bench SHALL connect memcpy_engine to a behavioural single-cycle byte-addressable memory of MEMSIZE bytes.

Verification
REQ-036 Forward copy: preload 0x000-0x00F with words 0x11111111..0x44444444; start src=0x000, dst=0x100, len=4 -> words at 0x100-0x10F match the source, done high 8 cycles after the accepting edge, error=0.
REQ-037 Overlapping backward copy: src=0x000, dst=0x004, len=3, source 0xA,0xB,0xC -> memory 0x000-0x00F reads 0xA,0xA,0xB,0xC.
REQ-038 Rejected requests: src=0x002 -> done=error=1 one cycle after start, mem_enable never asserted; separately dst=0x3FC, len=2 with MEMSIZE=0x400 -> same error response.
REQ-039 Zero length: len=0 -> done one cycle after start, no memory access, error=0.
REQ-040 Reset mid-copy: rst_n low during the WRITE of word 2 of len=4 -> all outputs 0 immediately, destination word 2 unchanged, and a following start copies correctly.
REQ-041 Ignored start and dump: start pulsed while busy is ignored (only one done); with DUMP_ON_DONE=1, createdump is high exactly in the done cycle.
